// File: rtl/pipeline_controller.sv
// Five-stage pipeline hazard/flow controller: boot flush, branch redirect,
// multi-cycle mul/div stall with timeout, load-use bubble, halt drain.
module pipeline_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_branch_taken,
    input  logic        ex_md_start,
    input  logic        md_done,
    input  logic        id_load_use,
    input  logic        id_halt,
    output logic        pc_stop,
    output logic        if_pc_mux,
    output logic        if_id_flush,
    output logic        if_id_hold,
    output logic        id_ex_flush,
    output logic        id_ex_hold,
    output logic        ex_mem_flush,
    output logic        halted,
    output logic        md_timeout,
    output logic [2:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        RUN     = 3'd1,
        MD_WAIT = 3'd2,
        DRAIN   = 3'd3,
        HALTED  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  boot_q, boot_d;
    logic [1:0]  drain_q, drain_d;
    logic [5:0]  wait_q, wait_d;
    logic        timeout_q, timeout_d;
    logic [15:0] stall_q, stall_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            boot_q    <= 2'd2;
            drain_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            boot_q    <= boot_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        boot_d       = boot_q;
        drain_d      = drain_q;
        wait_d       = wait_q;
        timeout_d    = timeout_q;
        pc_stop      = 1'b0;
        if_pc_mux    = 1'b0;
        if_id_flush  = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;

        case (state_q)
            BOOT: begin
                pc_stop     = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                boot_d      = boot_q - 2'd1;
                if (boot_q <= 2'd1) begin
                    boot_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Priority chain: branch squashes everything younger, including halt.
                if (ex_branch_taken) begin
                    if_pc_mux   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (ex_md_start) begin
                    pc_stop      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_flush = 1'b1;
                    wait_d       = '0;
                    state_d      = MD_WAIT;
                end else if (id_load_use) begin
                    pc_stop     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_halt) begin
                    pc_stop     = 1'b1;
                    if_id_flush = 1'b1;
                    drain_d     = 2'd3;
                    state_d     = DRAIN;
                end
            end
            MD_WAIT: begin
                if (md_done) begin
                    state_d = RUN;
                end else if (wait_q == 6'd63) begin
                    timeout_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    pc_stop      = 1'b1;
                    if_id_hold   = 1'b1;
                    id_ex_hold   = 1'b1;
                    ex_mem_flush = 1'b1;
                    wait_d       = wait_q + 6'd1;
                end
            end
            DRAIN: begin
                pc_stop     = 1'b1;
                if_id_flush = 1'b1;
                drain_d     = drain_q - 2'd1;
                if (drain_q <= 2'd1) begin
                    drain_d = '0;
                    state_d = HALTED;
                end
            end
            HALTED: begin
                pc_stop     = 1'b1;
                if_id_flush = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        stall_d = stall_q;
        if (pc_stop && (state_q == RUN || state_q == MD_WAIT) && (stall_q != 16'hFFFF))
            stall_d = stall_q + 16'd1;
    end

    assign state       = state_q;
    assign md_timeout  = timeout_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed, table-driven bench for pipeline_controller with hand-written
// multi-cycle sequences for reset abort, mul/div timeout and stall saturation.
module tb_pipeline_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_branch_taken, ex_md_start, md_done, id_load_use, id_halt;
    logic        pc_stop, if_pc_mux, if_id_flush, if_id_hold, id_ex_flush;
    logic        id_ex_hold, ex_mem_flush, halted, md_timeout;
    logic [2:0]  state;
    logic [15:0] stall_count;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    pipeline_controller dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .md_done         (md_done),
        .id_load_use     (id_load_use),
        .id_halt         (id_halt),
        .pc_stop         (pc_stop),
        .if_pc_mux       (if_pc_mux),
        .if_id_flush     (if_id_flush),
        .if_id_hold      (if_id_hold),
        .id_ex_flush     (id_ex_flush),
        .id_ex_hold      (id_ex_hold),
        .ex_mem_flush    (ex_mem_flush),
        .halted          (halted),
        .md_timeout      (md_timeout),
        .state           (state),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    // {pc_stop, if_pc_mux, if_id_flush, if_id_hold, id_ex_flush, id_ex_hold, ex_mem_flush, halted}
    assign ctl = {pc_stop, if_pc_mux, if_id_flush, if_id_hold,
                  id_ex_flush, id_ex_hold, ex_mem_flush, halted};

    localparam logic [7:0] C_BOOT = 8'hA8;
    localparam logic [7:0] C_IDLE = 8'h00;
    localparam logic [7:0] C_BR   = 8'h68;
    localparam logic [7:0] C_MD   = 8'h96;
    localparam logic [7:0] C_LU   = 8'h98;
    localparam logic [7:0] C_DRN  = 8'hA0;
    localparam logic [7:0] C_HLT  = 8'hA1;

    typedef struct packed {
        logic        br, mds, mdd, lu, hlt;
        logic [7:0]  ctl;
        logic [2:0]  st;
        logic [15:0] stall;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(input logic [4:0] in, input logic [7:0] c,
                                input logic [2:0] s, input logic [15:0] sc);
        vec_t v;
        {v.br, v.mds, v.mdd, v.lu, v.hlt} = in;
        v.ctl   = c;
        v.st    = s;
        v.stall = sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {ex_branch_taken, ex_md_start, md_done, id_load_use, id_halt} = in;
    endtask

    initial begin
        int bad;
        // inputs:        {br,mds,mdd,lu,hlt}
        tbl[0]  = mk(5'b00000, C_BOOT, 3'd0, 16'd0);
        tbl[1]  = mk(5'b00000, C_BOOT, 3'd0, 16'd0);
        tbl[2]  = mk(5'b00000, C_IDLE, 3'd1, 16'd0);
        tbl[3]  = mk(5'b10011, C_BR,   3'd1, 16'd0);
        tbl[4]  = mk(5'b00000, C_IDLE, 3'd1, 16'd0);
        tbl[5]  = mk(5'b00010, C_LU,   3'd1, 16'd0);
        tbl[6]  = mk(5'b00000, C_IDLE, 3'd1, 16'd1);
        tbl[7]  = mk(5'b01000, C_MD,   3'd1, 16'd1);
        tbl[8]  = mk(5'b00000, C_MD,   3'd2, 16'd2);
        tbl[9]  = mk(5'b10000, C_MD,   3'd2, 16'd3);
        tbl[10] = mk(5'b00010, C_MD,   3'd2, 16'd4);
        tbl[11] = mk(5'b00001, C_MD,   3'd2, 16'd5);
        tbl[12] = mk(5'b00100, C_IDLE, 3'd2, 16'd6);
        tbl[13] = mk(5'b00000, C_IDLE, 3'd1, 16'd6);
        tbl[14] = mk(5'b11000, C_BR,   3'd1, 16'd6);
        tbl[15] = mk(5'b01010, C_MD,   3'd1, 16'd6);
        tbl[16] = mk(5'b11100, C_IDLE, 3'd2, 16'd7);
        tbl[17] = mk(5'b00011, C_LU,   3'd1, 16'd7);
        tbl[18] = mk(5'b00001, C_DRN,  3'd1, 16'd8);
        tbl[19] = mk(5'b10000, C_DRN,  3'd3, 16'd9);
        tbl[20] = mk(5'b00000, C_DRN,  3'd3, 16'd9);
        tbl[21] = mk(5'b00000, C_DRN,  3'd3, 16'd9);
        tbl[22] = mk(5'b00000, C_HLT,  3'd4, 16'd9);
        tbl[23] = mk(5'b10001, C_HLT,  3'd4, 16'd9);

        rst_n = 1'b0;
        drive(5'b00000);
        @(negedge clk); #1;
        check("reset ctl", 32'(ctl), 32'(C_BOOT));
        check("reset state", 32'(state), 32'd0);
        check("reset stall", 32'(stall_count), 32'd0);
        check("reset timeout", 32'(md_timeout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            drive({tbl[i].br, tbl[i].mds, tbl[i].mdd, tbl[i].lu, tbl[i].hlt});
            #1;
            check($sformatf("v%0d ctl", i), 32'(ctl), 32'(tbl[i].ctl));
            check($sformatf("v%0d state", i), 32'(state), 32'(tbl[i].st));
            check($sformatf("v%0d stall", i), 32'(stall_count), 32'(tbl[i].stall));
            check($sformatf("v%0d timeout", i), 32'(md_timeout), 32'd0);
            @(negedge clk);
        end

        // Asynchronous reset out of HALTED
        drive(5'b00000);
        rst_n = 1'b0; #1;
        check("halt reset state", 32'(state), 32'd0);
        check("halt reset halted", 32'(halted), 32'd0);
        check("halt reset ctl", 32'(ctl), 32'(C_BOOT));
        check("halt reset stall", 32'(stall_count), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("reboot state", 32'(state), 32'd1);

        // Reset aborts a pending mul/div stall
        @(negedge clk);
        drive(5'b01000);
        @(negedge clk);
        drive(5'b00000); #1;
        check("md wait entered", 32'(state), 32'd2);
        rst_n = 1'b0; #1;
        check("md abort state", 32'(state), 32'd0);
        check("md abort ctl", 32'(ctl), 32'(C_BOOT));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("md abort run", 32'(state), 32'd1);
        check("md abort no hold", 32'(ctl), 32'(C_IDLE));
        check("md abort stall", 32'(stall_count), 32'd0);

        // Mul/div timeout: 63 hold cycles, then release with sticky error
        @(negedge clk);
        drive(5'b01000); #1;
        check("to start ctl", 32'(ctl), 32'(C_MD));
        @(negedge clk);
        drive(5'b00000);
        bad = 0;
        for (int k = 0; k < 63; k++) begin
            #1;
            if (ctl !== C_MD || state !== 3'd2 || md_timeout !== 1'b0) bad++;
            @(negedge clk);
        end
        check("to hold span", 32'(bad), 32'd0);
        #1;
        check("to release ctl", 32'(ctl), 32'(C_IDLE));
        check("to release state", 32'(state), 32'd2);
        check("to not yet", 32'(md_timeout), 32'd0);
        @(negedge clk); #1;
        check("to back run", 32'(state), 32'd1);
        check("to flag", 32'(md_timeout), 32'd1);
        check("to stall", 32'(stall_count), 32'd64);
        @(negedge clk);
        drive(5'b00010);
        @(negedge clk);
        drive(5'b00000); #1;
        check("to sticky", 32'(md_timeout), 32'd1);
        check("to lu stall", 32'(stall_count), 32'd65);
        rst_n = 1'b0; #1;
        check("to reset clear", 32'(md_timeout), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);

        // Stall counter saturation under continuous load-use
        drive(5'b00010);
        for (int n = 0; n < 65540; n++) begin
            #1;
            if (n == 65534) check("sat FFFE", 32'(stall_count), 32'hFFFE);
            if (n == 65535) check("sat FFFF", 32'(stall_count), 32'hFFFF);
            @(negedge clk);
        end
        #1;
        check("sat hold", 32'(stall_count), 32'hFFFF);
        check("sat ctl", 32'(ctl), 32'(C_LU));
        drive(5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clock input 1 (rising edge) and reset input 1 (0 = reset asserted).
REQ-002 ex_branch_taken  input  1  taken branch resolved in EX this cycle.
REQ-003 ex_md_start  input  1  multi-cycle mul/div instruction entered EX this cycle.
REQ-004 md_done  input  1  mul/div unit result valid this cycle.
REQ-005 id_load_use  input  1  load-use hazard detected in ID.
REQ-006 id_halt  input  1  halt instruction decoded in ID.
REQ-007 pc_stop  output  1  freeze program counter.
REQ-008 if_pc_mux  output  1  select branch target into PC (1) vs PC+2 (0).
REQ-009 if_id_flush, if_id_hold, id_ex_flush, id_ex_hold, ex_mem_flush  output  1 each  pipeline buffer controls.
REQ-010 halted  output  1  CPU halted; md_timeout  output  1  sticky mul/div timeout error.
REQ-011 state  output  3  BOOT=0, RUN=1, MD_WAIT=2, DRAIN=3, HALTED=4.
REQ-012 stall_count  output  16  saturating count of hazard stall cycles.

Function
REQ-013 Registered FSM states SHALL be BOOT, RUN, MD_WAIT, DRAIN, HALTED; all buffer/PC outputs SHALL be combinational from state and inputs; outputs not named in a rule SHALL be 0.
REQ-014 BOOT: pc_stop=1, if_id_flush=1, id_ex_flush=1 for exactly 2 cycles after reset release (2-bit counter), then RUN.
REQ-015 RUN priority, highest first: ex_branch_taken > ex_md_start > id_load_use > id_halt.
REQ-016 RUN + ex_branch_taken: if_pc_mux=1, if_id_flush=1, id_ex_flush=1; stay RUN; lower-priority requests that cycle SHALL be ignored.
REQ-017 RUN + ex_md_start: pc_stop=1, if_id_hold=1, id_ex_hold=1, ex_mem_flush=1; next state MD_WAIT; 6-bit wait counter cleared.
REQ-018 RUN + id_load_use: pc_stop=1, if_id_hold=1, id_ex_flush=1 for that cycle only; stay RUN.
REQ-019 RUN + id_halt: pc_stop=1, if_id_flush=1; next state DRAIN; drain counter loaded with 3.
REQ-020 MD_WAIT + md_done=0: pc_stop=1, if_id_hold=1, id_ex_hold=1, ex_mem_flush=1; counter increments.
REQ-021 MD_WAIT + md_done=1: no hold/flush asserted that cycle; next state RUN.
REQ-022 MD_WAIT counter reaching 63 with md_done=0 SHALL set md_timeout (sticky until reset), release holds that cycle, return to RUN.
REQ-023 MD_WAIT SHALL ignore ex_branch_taken, id_load_use, id_halt, ex_md_start.
REQ-024 ex_md_start arriving in the cycle md_done=1 in MD_WAIT SHALL be ignored (design contract: cannot occur).
REQ-025 DRAIN: pc_stop=1, if_id_flush=1; counter decrements each cycle; at counter=1 next state HALTED; all inputs ignored.
REQ-026 HALTED: pc_stop=1, if_id_flush=1, halted=1; exit only via reset.
REQ-027 stall_count SHALL increment by 1 each cycle pc_stop=1 in RUN or MD_WAIT, saturate at 16'hFFFF, not count BOOT/DRAIN/HALTED.
REQ-028 Simultaneous branch and halt in RUN SHALL take the branch; halt is squashed by the flush.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force state=BOOT, boot counter=2, md_timeout=0, stall_count=0, halted=0, drain/wait counters=0.
REQ-030 While reset=0: pc_stop=1, if_id_flush=1, id_ex_flush=1, all other outputs 0.
REQ-031 Reset asserted mid-operation in any state SHALL abort it with the REQ-029 values; no pending stall/drain survives.

Verification
REQ-032 Release reset, all inputs 0 -> pc_stop=1 for 2 cycles, state 0->0->1, then all controls 0.
REQ-033 RUN, ex_branch_taken=1 with id_load_use=1 and id_halt=1 -> if_pc_mux=1, if_id_flush=1, id_ex_flush=1, pc_stop=0, state stays 1, stall_count unchanged.
REQ-034 RUN, ex_md_start pulse, md_done high 5 cycles later -> holds asserted 5 cycles, released on done cycle, state 1->2->1, stall_count +5.
REQ-035 RUN, ex_md_start, md_done never -> md_timeout=1 after 64 MD_WAIT-related cycles, state returns 1, md_timeout stays 1.
REQ-036 RUN, id_halt pulse -> state 3 for 3 cycles then 4, halted=1, pc_stop=1 held; reset pulse -> state 0, halted=0.
REQ-037 Force 65540 consecutive load-use cycles -> stall_count holds 16'hFFFF with no wrap.
